// File: rtl/coef_piso_streamer.sv
// coef_piso_streamer: parallel-in, serial-out streamer for polynomial coefficients.
// Accepts LENGTH coefficients in one parallel load, then emits them element 0 first
// on a valid/ready stream. A new block may load in the same cycle the last beat fires.
// Optional macro PISO_CLKEN_EN adds a clock-enable input (clken).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clken             clock enable (PISO_CLKEN_EN only)
//   load_valid/ready  parallel block handshake, load_data = LENGTH x WIDTH block
//   out_valid/ready   serial coefficient handshake
//   out_data          current coefficient
//   out_last          current coefficient is the final element of its block
//   busy              a block is held
module coef_piso_streamer #(
    parameter int LENGTH = 6,
    parameter int WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef PISO_CLKEN_EN
    input  logic                    clken,
`endif
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [LENGTH*WIDTH-1:0] load_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic                    busy
);
    localparam int CW = $clog2(LENGTH + 1);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg [LENGTH];
    logic             en;
    logic             cnt_one;
    logic             load_fire;
    logic             out_fire;
`ifdef PISO_CLKEN_EN
    assign en = clken;
`else
    assign en = 1'b1;
`endif
    assign cnt_one    = cnt == CW'(1);
    assign busy       = state == STREAM;
    assign out_valid  = busy && en;
    assign out_data   = shreg[0];
    assign out_last   = cnt_one;
    // Combinational path out_ready -> load_ready lets the next block overlap the last beat.
    assign load_ready = !rst && en && (state == IDLE || (busy && cnt_one && out_ready));
    assign load_fire  = load_valid && load_ready;
    assign out_fire   = out_valid && out_ready;
    // Every update is conditioned on a fire, and both fires are gated by en,
    // so all registers hold while the enable is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            for (int k = 0; k < LENGTH; k++) shreg[k] <= '0;
        end else if (load_fire) begin
            state <= STREAM;
            cnt   <= CW'(LENGTH);
            for (int k = 0; k < LENGTH; k++) shreg[k] <= load_data[WIDTH*k +: WIDTH];
        end else if (out_fire) begin
            state <= cnt_one ? IDLE : STREAM;
            cnt   <= cnt - CW'(1);
            for (int k = 0; k < LENGTH - 1; k++) shreg[k] <= shreg[k+1];
            shreg[LENGTH-1] <= '0;
        end
    end
endmodule

// File: tb/tb_coef_piso_streamer.sv
// tb_coef_piso_streamer: scoreboard bench for coef_piso_streamer.
module tb_coef_piso_streamer;
    localparam int LENGTH = 6;
    localparam int WIDTH  = 16;
    logic                    clk = 1'b0;
    logic                    rst;
`ifdef PISO_CLKEN_EN
    logic                    clken;
`endif
    logic                    load_valid;
    logic                    load_ready;
    logic [LENGTH*WIDTH-1:0] load_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_last;
    logic                    busy;
    int                      n_cmp = 0;
    int                      n_err = 0;
    logic [WIDTH:0]          sb [$];
    always #5 clk = ~clk;
    coef_piso_streamer #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
`ifdef PISO_CLKEN_EN
        .clken(clken),
`endif
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data(load_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [LENGTH*WIDTH-1:0] blk(input logic [WIDTH-1:0] base);
        logic [LENGTH*WIDTH-1:0] b;
        for (int k = 0; k < LENGTH; k++) b[WIDTH*k +: WIDTH] = base + WIDTH'(k);
        return b;
    endfunction
    // Inputs change 1 time unit after the rising edge, so the falling edge sees
    // exactly the values that decide the next edge's fires.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (rst) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("beat", {15'd0, out_last, out_data}, {15'd0, e});
                end
            end
            if (load_valid && load_ready)
                for (int k = 0; k < LENGTH; k++)
                    sb.push_back({k == LENGTH - 1, load_data[WIDTH*k +: WIDTH]});
        end
    end
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        out_ready = 1'b0;
`ifdef PISO_CLKEN_EN
        clken = 1'b1;
`endif
        cyc;
        cyc;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_lready", load_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_lready", load_ready, 1);
        // single block
        load_data = blk(16'h0001);
        load_valid = 1'b1;
        out_ready = 1'b1;
        cyc;
        load_valid = 1'b0;
        check("first_valid", out_valid, 1);
        check("first_data", out_data, 16'h0001);
        check("first_busy", busy, 1);
        repeat (LENGTH) cyc;
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        check("idle_lready", load_ready, 1);
        // backpressure at element 2
        load_valid = 1'b1;
        cyc;
        load_valid = 1'b0;
        cyc;
        cyc;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc;
            check("bp_data", out_data, 16'h0003);
            check("bp_valid", out_valid, 1);
            check("bp_last", out_last, 0);
        end
        out_ready = 1'b1;
        repeat (4) cyc;
        check("bp_done_busy", busy, 0);
        // back-to-back blocks; the second block waits on load_valid while the first streams
        load_valid = 1'b1;
        cyc;
        load_data = blk(16'h0101);
        check("blocked_lready", load_ready, 0);
        check("b2b_first", out_data, 16'h0001);
        for (int i = 0; i < 2 * LENGTH; i++) begin
            check("b2b_valid", out_valid, 1);
            if (i == LENGTH - 1) begin
                check("b2b_last", out_last, 1);
                check("b2b_lready", load_ready, 1);
                check("b2b_data5", out_data, 16'h0006);
            end
            if (i == LENGTH) begin
                check("b2b_next", out_data, 16'h0101);
                load_valid = 1'b0;
            end
            cyc;
        end
        check("b2b_done_busy", busy, 0);
        // mid-stream reset after element 3
        load_data = blk(16'h0201);
        load_valid = 1'b1;
        cyc;
        load_valid = 1'b0;
        repeat (3) cyc;
        check("pre_rst_data", out_data, 16'h0204);
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_data", out_data, 0);
        check("mrst_last", out_last, 0);
        load_data = blk(16'h0301);
        load_valid = 1'b1;
        #1;
        cyc;
        load_valid = 1'b0;
        check("after_rst_data", out_data, 16'h0301);
`ifdef PISO_CLKEN_EN
        cyc;
        clken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc;
            check("ce_valid", out_valid, 0);
            check("ce_data", out_data, 16'h0302);
        end
        clken = 1'b1;
        #1;
        check("ce_resume", out_data, 16'h0302);
        repeat (LENGTH - 1) cyc;
`else
        repeat (LENGTH) cyc;
`endif
        check("end_busy", busy, 0);
        repeat (2) cyc;
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
